// File: rtl/wptr_full_ctrl.sv
// Write-side pointer, full/almost-full and fill-level control for an async FIFO.
// Optional sticky overflow detection is enabled by defining WPTR_OVF_DETECT_EN.
module wptr_full_ctrl #(
    parameter int ADDR_WIDTH   = 9,
    parameter int AFULL_THRESH = 2**ADDR_WIDTH - 4
) (
    input  logic                  w_clk,
    input  logic                  wrst,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
    input  logic                  ovf_clr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  w_ack,
    output logic                  f_full,
    output logic                  w_afull,
    output logic [ADDR_WIDTH:0]   w_level,
    output logic                  w_ovf
);

    localparam int W   = ADDR_WIDTH + 1;
    localparam int MSB = ADDR_WIDTH;
    localparam logic [W-1:0] AFULL_T = W'(AFULL_THRESH);

    logic [W-1:0] wptr_next;
    logic [W-1:0] gray_next;
    logic [W-1:0] rptr_bin;
    logic [W-1:0] level_next;
    logic         full_next;
    logic         afull_next;

    // Gated by reset so no acknowledge can leak out while the block is held.
    assign w_ack = w_en & ~f_full & wrst;

    assign wptr_next  = wptr + W'(w_ack);
    assign gray_next  = (wptr_next >> 1) ^ wptr_next;
    assign level_next = wptr_next - rptr_bin;
    assign afull_next = (level_next >= AFULL_T);

    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    assign full_next = (gray_next == {~rptr_gray_sync[MSB:MSB-1], rptr_gray_sync[MSB-2:0]});

    always_comb begin
        rptr_bin      = '0;
        rptr_bin[W-1] = rptr_gray_sync[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            rptr_bin[i] = rptr_bin[i+1] ^ rptr_gray_sync[i];
        end
    end

    always_ff @(posedge w_clk or negedge wrst) begin
        if (!wrst) begin
            wptr      <= '0;
            wptr_gray <= '0;
            w_level   <= '0;
            f_full    <= 1'b0;
            w_afull   <= 1'b0;
        end else begin
            wptr      <= wptr_next;
            wptr_gray <= gray_next;
            w_level   <= level_next;
            f_full    <= full_next;
            w_afull   <= afull_next;
        end
    end

`ifdef WPTR_OVF_DETECT_EN
    // Set has priority over clear so an overflow in the clearing cycle is kept.
    always_ff @(posedge w_clk or negedge wrst) begin
        if (!wrst) begin
            w_ovf <= 1'b0;
        end else if (w_en && f_full) begin
            w_ovf <= 1'b1;
        end else if (ovf_clr) begin
            w_ovf <= 1'b0;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign w_ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl at default parameters (depth 512, afull 508).
module tb_wptr_full_ctrl;

    localparam int AW = 9;
    localparam int W  = AW + 1;

    logic         w_clk = 1'b0;
    logic         wrst  = 1'b0;
    logic         w_en  = 1'b0;
    logic [W-1:0] rptr_gray_sync = '0;
    logic         ovf_clr = 1'b0;
    logic [W-1:0] wptr, wptr_gray, w_level;
    logic         w_ack, f_full, w_afull, w_ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] wptr;
        logic [W-1:0] gray;
        logic [W-1:0] level;
        logic         full;
        logic         afull;
        logic         ovf;
    } exp_t;

    exp_t sb[$];

    logic [W-1:0] m_w, m_r, m_level;
    logic         m_full, m_afull, m_ovf;
    logic [W-1:0] prev_gray;

    wptr_full_ctrl dut (
        .w_clk(w_clk), .wrst(wrst), .w_en(w_en), .rptr_gray_sync(rptr_gray_sync),
        .ovf_clr(ovf_clr), .wptr(wptr), .wptr_gray(wptr_gray), .w_ack(w_ack),
        .f_full(f_full), .w_afull(w_afull), .w_level(w_level), .w_ovf(w_ovf)
    );

    always #5 w_clk = ~w_clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_w = '0; m_r = '0; m_level = '0;
        m_full = 1'b0; m_afull = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wptr"},  wptr, '0);
        chk({tag, "_gray"},  wptr_gray, '0);
        chk({tag, "_level"}, w_level, '0);
        chk({tag, "_full"},  W'(f_full), '0);
        chk({tag, "_afull"}, W'(w_afull), '0);
        chk({tag, "_ovf"},   W'(w_ovf), '0);
        chk({tag, "_ack"},   W'(w_ack), '0);
    endtask

    // One clock of stimulus: drive, predict, then compare after the edge.
    task automatic step(input logic en, input logic [W-1:0] rnext, input logic clr);
        exp_t e;
        logic acc;
        @(negedge w_clk);
        w_en = en;
        rptr_gray_sync = to_gray(rnext);
        ovf_clr = clr;
        #1;
        acc = en && !m_full;
        chk("ack", W'(w_ack), W'(acc));
`ifdef WPTR_OVF_DETECT_EN
        if (en && m_full) m_ovf = 1'b1;
        else if (clr)     m_ovf = 1'b0;
`endif
        if (acc) m_w = m_w + 1'b1;
        m_r     = rnext;
        m_level = m_w - m_r;
        m_full  = (m_level == W'(512));
        m_afull = (m_level >= W'(508));
        e.wptr = m_w; e.gray = to_gray(m_w); e.level = m_level;
        e.full = m_full; e.afull = m_afull; e.ovf = m_ovf;
        sb.push_back(e);
        @(posedge w_clk);
        #1;
        e = sb.pop_front();
        chk("wptr",  wptr, e.wptr);
        chk("gray",  wptr_gray, e.gray);
        chk("level", w_level, e.level);
        chk("full",  W'(f_full), W'(e.full));
        chk("afull", W'(w_afull), W'(e.afull));
        chk("ovf",   W'(w_ovf), W'(e.ovf));
    endtask

    initial begin
        model_reset();
        w_en = 1'b1;
        #3;
        check_all_zero("rst_init");
        @(negedge w_clk);
        wrst = 1'b1;
        w_en = 1'b0;

        for (int i = 0; i < 37; i++) step(1'b1, '0, 1'b0);
        chk("pre_rst_wptr", wptr, W'(37));

        // Asynchronous reset between edges with a write pending.
        @(negedge w_clk);
        w_en = 1'b1;
        #2;
        wrst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        model_reset();
        @(negedge w_clk);
        w_en = 1'b0;
        wrst = 1'b1;

        for (int i = 0; i < 512; i++) begin
            step(1'b1, '0, 1'b0);
            if (i == 506) chk("afull_507", W'(w_afull), '0);
            if (i == 507) chk("afull_508", W'(w_afull), W'(1));
        end
        chk("fill_wptr",  wptr, W'('h200));
        chk("fill_gray",  wptr_gray, W'('h300));
        chk("fill_level", w_level, W'(512));
        chk("fill_full",  W'(f_full), W'(1));

        step(1'b1, '0, 1'b0);
        chk("ovf_hold_wptr", wptr, W'('h200));
`ifdef WPTR_OVF_DETECT_EN
        chk("ovf_set", W'(w_ovf), W'(1));
`else
        chk("ovf_tied", W'(w_ovf), '0);
`endif
        step(1'b0, '0, 1'b1);
        chk("ovf_clr", W'(w_ovf), '0);
        step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        step(1'b0, W'(1), 1'b0);
        chk("drain_full",  W'(f_full), '0);
        chk("drain_level", w_level, W'(511));
        step(1'b1, W'(2), 1'b0);
        chk("wr_rd_level", w_level, W'(511));

        while (m_w != W'(1023)) step(1'b1, m_r + 1'b1, 1'b0);
        prev_gray = wptr_gray;
        chk("wrap_prev_gray", prev_gray, W'('h200));
        step(1'b1, m_r + 1'b1, 1'b0);
        chk("wrap_wptr", wptr, '0);
        chk("wrap_gray", wptr_gray, '0);
        chk("wrap_full", W'(f_full), '0);

        for (int i = 0; i < 300; i++) begin
            logic adv;
            adv = ($urandom_range(0, 2) == 0) && (m_w != m_r);
            step(1'(($urandom_range(0, 3) != 0)), m_r + W'(adv), 1'(($urandom_range(0, 9) == 0)));
        end

        chk("sb_empty", W'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9: FIFO address width; depth = 2**ADDR_WIDTH; legal range 2..16.
REQ-002 SHALL have parameter AFULL_THRESH, default 2**ADDR_WIDTH-4: fill level at which w_afull asserts; legal range 1..2**ADDR_WIDTH.
REQ-003 SHALL have port w_clk  input  1  write-domain clock; the only clock.
REQ-004 SHALL have port wrst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port w_en  input  1  write request.
REQ-006 SHALL have port rptr_gray_sync  input  ADDR_WIDTH+1  read pointer (Gray), already synchronised into w_clk.
REQ-007 SHALL have port ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 SHALL have port wptr  output  ADDR_WIDTH+1  binary write pointer; the low ADDR_WIDTH bits are the RAM write address.
REQ-009 SHALL have port wptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, for crossing to the read domain.
REQ-010 SHALL have port w_ack  output  1  pulses for one cycle in the cycle a write is accepted (combinational: w_en && !f_full).
REQ-011 SHALL have port f_full  output  1  registered full flag.
REQ-012 SHALL have port w_afull  output  1  registered almost-full flag.
REQ-013 SHALL have port w_level  output  ADDR_WIDTH+1  registered fill level, range 0..2**ADDR_WIDTH.
REQ-014 SHALL have port w_ovf  output  1  sticky overflow flag.

Function
REQ-015 A write SHALL be accepted when w_en=1 and f_full=0; writes with f_full=1 are dropped and leave the pointer unchanged.
REQ-016 wptr_next SHALL be wptr+1 on an accepted write, else wptr; the addition is modulo 2**(ADDR_WIDTH+1), so 2**(ADDR_WIDTH+1)-1 wraps to 0.
REQ-017 wptr and wptr_gray SHALL both update from wptr_next on the same edge; wptr_gray = (wptr_next>>1)^wptr_next, registered, and never lags wptr.
REQ-018 f_full SHALL register (gray(wptr_next) == {~rptr_gray_sync[MSB:MSB-1], rptr_gray_sync[MSB-2:0]}), so it asserts on the same edge as the write that fills the FIFO.
REQ-019 w_level SHALL register wptr_next - gray2bin(rptr_gray_sync), modulo 2**(ADDR_WIDTH+1).
REQ-020 w_afull SHALL register (level_next >= AFULL_THRESH); it is updated on the same edge as w_level.
REQ-021 A change on rptr_gray_sync SHALL be reflected in f_full, w_level and w_afull one w_clk edge later; a write and a read-pointer advance in the same cycle net out correctly.
REQ-022 Full-to-not-full SHALL depend only on rptr_gray_sync movement; w_en has no effect on this transition.

Reset
REQ-023 While wrst=0, wptr, wptr_gray, w_level, f_full, w_afull and w_ovf SHALL be 0, asynchronously, independent of w_clk.
REQ-024 Release of wrst SHALL be honoured on the next w_clk edge; a write in progress at reset assertion is lost.
REQ-025 w_ack SHALL be 0 while wrst=0.

Configuration
REQ-026 Macro WPTR_OVF_DETECT_EN defined: w_ovf SHALL set on any edge with w_en=1 and f_full=1, and stay set until ovf_clr=1 clears it on an edge; set wins over clear when both occur in the same cycle.
REQ-027 Macro WPTR_OVF_DETECT_EN undefined: w_ovf SHALL be tied to 0, ovf_clr SHALL be ignored, and the port list SHALL be unchanged.

Verification
REQ-028 Reset check: assert wrst mid-stream with wptr=37 -> all registered outputs are 0 immediately, without a clock edge.
REQ-029 Fill check: ADDR_WIDTH=9, rptr_gray_sync=0, 512 back-to-back writes ->
- f_full=1 on the edge of write 512;
- wptr=0x200, wptr_gray=0x300, w_level=512.
REQ-030 Almost-full and overflow check: AFULL_THRESH=508 ->
- w_afull rises on the edge where w_level becomes 508;
- with the FIFO full, a further w_en -> wptr holds at 0x200, w_ack=0, w_ovf=1 (macro defined) or 0 (undefined).
REQ-031 Drain check: FIFO full, rptr_gray_sync changes to 0x001 -> one edge later f_full=0, w_level=511; a simultaneous write plus read advance keeps w_level constant.
REQ-032 Wrap check: preload wptr=1023 by writing and reading continuously -> next accepted write gives wptr=0 and wptr_gray=0x000 (previous value 0x200); no false f_full.
REQ-033 Overflow clear check: w_ovf=1, pulse ovf_clr with w_en=0 -> w_ovf=0 next edge; ovf_clr together with an overflowing write -> w_ovf stays 1.
